// File: rtl/iuq_uc_credit_return.sv
// ---------------------------------------------------------------------------
// iuq_uc_credit_return
//
// Completion-side credit return engine for the microcode completion buffer.
// Tracks microcode instructions that entered completion (outstanding) and
// completions whose credit has not yet been handed back (pending), and
// returns at most one credit per cycle to the IU microcode unit.
//
// Ports:
//   nclk              - clock, rising edge
//   reset             - asynchronous active-high reset
//   uc_cp_issue       - one ucode instruction entered completion
//   cp_cmplt_uc[1:0]  - per-slot ucode completion (slot 0 older)
//   cp_flush          - flush of the ucode stream
//   cp_flush_into_uc  - flush restarting inside ucode (oldest stays live)
//   cp_uc_credit_free - registered one-cycle credit-return pulse
//   outstanding_cnt   - issued but not yet completed
//   pending_cnt       - completed, credit not yet returned
//   credit_idle       - nothing outstanding, pending or being returned
//   err_overflow      - sticky: issue with all credits already in use
//   err_underflow     - sticky: more completions than outstanding
// ---------------------------------------------------------------------------
module iuq_uc_credit_return #(
  parameter int CREDITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic             nclk,
  input  logic             reset,
  input  logic             uc_cp_issue,
  input  logic [1:0]       cp_cmplt_uc,
  input  logic             cp_flush,
  input  logic             cp_flush_into_uc,
  output logic             cp_uc_credit_free,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             credit_idle,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CREDITS_C  = CNT_W'(CREDITS);
  localparam logic [SUM_W-1:0] CREDITS_SC = SUM_W'(CREDITS);

  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             free_q, free_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic [1:0]       cmp_s;
  logic [CNT_W-1:0] cmp_w_s;
  logic [CNT_W-1:0] cmp_ok_s;
  logic [CNT_W-1:0] avail_s;
  logic [SUM_W-1:0] in_use_s;
  logic [CNT_W:0]   out_sum_s;

  // Next-state computation: flush handling, credit return and error detection
  always_comb begin
    cmp_s     = {1'b0, cp_cmplt_uc[0]} + {1'b0, cp_cmplt_uc[1]};
    cmp_w_s   = {{(CNT_W-2){1'b0}}, cmp_s};
    // Completions beyond what is outstanding are bogus and not counted.
    if (cmp_w_s > out_q) begin
      cmp_ok_s = out_q;
    end else begin
      cmp_ok_s = cmp_w_s;
    end
    avail_s   = pend_q + cmp_ok_s;
    // Credits held away from the issue side: outstanding, pending, in flight.
    in_use_s  = {2'b00, out_q} + {2'b00, pend_q} + {{(SUM_W-1){1'b0}}, free_q};
    // cmp_ok_s never exceeds out_q, so this cannot go negative.
    out_sum_s = {1'b0, out_q} + {{CNT_W{1'b0}}, uc_cp_issue} - {1'b0, cmp_ok_s};

    out_d     = out_q;
    pend_d    = pend_q;
    free_d    = 1'b0;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;

    if (cp_flush_into_uc) begin
      out_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      pend_d = {CNT_W{1'b0}};
      free_d = 1'b0;
    end else if (cp_flush) begin
      out_d  = {CNT_W{1'b0}};
      pend_d = {CNT_W{1'b0}};
      free_d = 1'b0;
    end else begin
      free_d = (avail_s != {CNT_W{1'b0}});
      pend_d = avail_s - {{(CNT_W-1){1'b0}}, free_d};
      if (out_sum_s > {1'b0, CREDITS_C}) begin
        out_d = CREDITS_C;
      end else begin
        out_d = out_sum_s[CNT_W-1:0];
      end
      if (uc_cp_issue && (in_use_s == CREDITS_SC)) begin
        err_ovf_d = 1'b1;
      end else begin
        err_ovf_d = err_ovf_q;
      end
      if (cmp_w_s > out_q) begin
        err_unf_d = 1'b1;
      end else begin
        err_unf_d = err_unf_q;
      end
    end
  end

  // State registers; error flags only clear on reset
  always_ff @(posedge nclk or posedge reset) begin
    if (reset) begin
      out_q     <= {CNT_W{1'b0}};
      pend_q    <= {CNT_W{1'b0}};
      free_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      pend_q    <= pend_d;
      free_q    <= free_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign cp_uc_credit_free = free_q;
  assign outstanding_cnt   = out_q;
  assign pending_cnt       = pend_q;
  assign credit_idle       = (out_q == {CNT_W{1'b0}}) && (pend_q == {CNT_W{1'b0}}) && !free_q;
  assign err_overflow      = err_ovf_q;
  assign err_underflow     = err_unf_q;

endmodule

// File: tb/tb_iuq_uc_credit_return.sv
// ---------------------------------------------------------------------------
// tb_iuq_uc_credit_return
//
// Self-checking bench: directed scenarios with hand-computed expectations,
// followed by randomized traffic compared every cycle against a behavioural
// model of the credit bookkeeping.
// ---------------------------------------------------------------------------
module tb_iuq_uc_credit_return;

  localparam int CREDITS = 8;
  localparam int CNT_W   = 4;

  logic             nclk;
  logic             reset;
  logic             uc_cp_issue;
  logic [1:0]       cp_cmplt_uc;
  logic             cp_flush;
  logic             cp_flush_into_uc;
  logic             cp_uc_credit_free;
  logic [CNT_W-1:0] outstanding_cnt;
  logic [CNT_W-1:0] pending_cnt;
  logic             credit_idle;
  logic             err_overflow;
  logic             err_underflow;

  iuq_uc_credit_return #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .nclk              (nclk),
    .reset             (reset),
    .uc_cp_issue       (uc_cp_issue),
    .cp_cmplt_uc       (cp_cmplt_uc),
    .cp_flush          (cp_flush),
    .cp_flush_into_uc  (cp_flush_into_uc),
    .cp_uc_credit_free (cp_uc_credit_free),
    .outstanding_cnt   (outstanding_cnt),
    .pending_cnt       (pending_cnt),
    .credit_idle       (credit_idle),
    .err_overflow      (err_overflow),
    .err_underflow     (err_underflow)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: counts of instructions in flight and credits owed.
  int m_out, m_pend, m_free, m_eovf, m_eunf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_out = 0; m_pend = 0; m_free = 0; m_eovf = 0; m_eunf = 0;
  endtask

  task automatic model_step(input int iss, input int c0, input int c1,
                            input int fl, input int fiu);
    int done, counted, owed, nfree;
    if (fiu != 0) begin
      m_out = 1; m_pend = 0; m_free = 0;
    end else if (fl != 0) begin
      m_out = 0; m_pend = 0; m_free = 0;
    end else begin
      done    = c0 + c1;
      counted = (done < m_out) ? done : m_out;
      if (done > m_out) m_eunf = 1;
      if (iss != 0 && (m_out + m_pend + m_free) == CREDITS) m_eovf = 1;
      owed   = m_pend + counted;
      nfree  = (owed > 0) ? 1 : 0;
      m_pend = owed - nfree;
      m_out  = m_out + iss - counted;
      if (m_out > CREDITS) m_out = CREDITS;
      m_free = nfree;
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic iss, input logic [1:0] c,
                      input logic fl, input logic fiu);
    uc_cp_issue      = iss;
    cp_cmplt_uc      = c;
    cp_flush         = fl;
    cp_flush_into_uc = fiu;
    @(posedge nclk);
    model_step(int'(iss), int'(c[0]), int'(c[1]), int'(fl), int'(fiu));
    #1;
  endtask

  task automatic idle_inputs();
    uc_cp_issue = 1'b0; cp_cmplt_uc = 2'b00; cp_flush = 1'b0; cp_flush_into_uc = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_free"}, int'(cp_uc_credit_free), 0);
    chk({tag, "_out"},  int'(outstanding_cnt),   0);
    chk({tag, "_pend"}, int'(pending_cnt),       0);
    chk({tag, "_idle"}, int'(credit_idle),       1);
    chk({tag, "_eovf"}, int'(err_overflow),      0);
    chk({tag, "_eunf"}, int'(err_underflow),     0);
  endtask

  // Assert reset away from any edge, check it acts before the next edge.
  task automatic async_reset(input string tag);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    model_clear();
    @(posedge nclk);
    #2;
    reset = 1'b0;
    @(posedge nclk);
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge nclk) begin
    if (chk_en) begin
      chk("cyc_free", int'(cp_uc_credit_free), m_free);
      chk("cyc_out",  int'(outstanding_cnt),   m_out);
      chk("cyc_pend", int'(pending_cnt),       m_pend);
      chk("cyc_idle", int'(credit_idle), (m_out == 0 && m_pend == 0 && m_free == 0) ? 1 : 0);
      chk("cyc_eovf", int'(err_overflow),      m_eovf);
      chk("cyc_eunf", int'(err_underflow),     m_eunf);
    end
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge nclk);
    #3;
    reset = 1'b0;
    @(posedge nclk);
    #1;
    chk_reset_vals("rst");
    chk_en = 1'b1;

    // Three issues, dual completion, then single completion.
    repeat (3) step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("t1_out3", int'(outstanding_cnt), 3);
    step(1'b0, 2'b11, 1'b0, 1'b0);
    chk("t1_p1_free", int'(cp_uc_credit_free), 1);
    chk("t1_p1_pend", int'(pending_cnt), 1);
    step(1'b0, 2'b10, 1'b0, 1'b0);
    chk("t1_p2_free", int'(cp_uc_credit_free), 1);
    chk("t1_p2_pend", int'(pending_cnt), 1);
    chk("t1_p2_out",  int'(outstanding_cnt), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_p3_free", int'(cp_uc_credit_free), 1);
    chk("t1_p3_pend", int'(pending_cnt), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_end_free", int'(cp_uc_credit_free), 0);
    chk("t1_end_idle", int'(credit_idle), 1);

    // Fill all credits, then one more issue.
    repeat (8) step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("t2_full", int'(outstanding_cnt), 8);
    chk("t2_no_ovf_yet", int'(err_overflow), 0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("t2_ovf", int'(err_overflow), 1);
    chk("t2_sat", int'(outstanding_cnt), 8);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("t2_ovf_sticky", int'(err_overflow), 1);
    chk("t2_flush_out", int'(outstanding_cnt), 0);

    // Flush while one credit is still pending.
    async_reset("r3");
    repeat (5) step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b11, 1'b0, 1'b0);
    chk("t3_pend1", int'(pending_cnt), 1);
    cp_flush = 1'b1;
    #1;
    chk("t3_pulse_in_flush", int'(cp_uc_credit_free), 1);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("t3_free_after", int'(cp_uc_credit_free), 0);
    chk("t3_out0", int'(outstanding_cnt), 0);
    chk("t3_pend0", int'(pending_cnt), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t3_no_more", int'(cp_uc_credit_free), 0);

    // Flush-into-ucode wins over flush and over a same-cycle completion.
    repeat (4) step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    chk("t4_out1", int'(outstanding_cnt), 1);
    chk("t4_pend0", int'(pending_cnt), 0);
    chk("t4_free0", int'(cp_uc_credit_free), 0);

    // Dual completion against a single outstanding instruction.
    step(1'b0, 2'b11, 1'b0, 1'b0);
    chk("t5_unf", int'(err_underflow), 1);
    chk("t5_free", int'(cp_uc_credit_free), 1);
    chk("t5_out0", int'(outstanding_cnt), 0);
    chk("t5_pend0", int'(pending_cnt), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t5_one_only", int'(cp_uc_credit_free), 0);

    // Reset mid-burst with three credits pending.
    async_reset("r6a");
    repeat (6) step(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (3) step(1'b0, 2'b11, 1'b0, 1'b0);
    chk("t6_pend3", int'(pending_cnt), 3);
    async_reset("r6b");
    repeat (3) begin
      step(1'b0, 2'b00, 1'b0, 1'b0);
      chk("t6_no_pulse", int'(cp_uc_credit_free), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        async_reset("rnd_rst");
      end else begin
        step(($urandom_range(99) < 40) ? 1'b1 : 1'b0,
             {($urandom_range(99) < 25) ? 1'b1 : 1'b0, ($urandom_range(99) < 30) ? 1'b1 : 1'b0},
             ($urandom_range(99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 2) ? 1'b1 : 1'b0);
      end
    end

    idle_inputs();
    @(negedge nclk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
